tree_res_pipe_adapter: RTL

- Adapts a fixed-latency, non-backpressurable arithmetic pipeline (e.g. a Montgomery multiplier) to the single-beat if_axi_stream request/response pair used by the tree resource-share fabric.
- Sits directly downstream of the resource share's o_res port. Its response output feeds the resource share's i_res port.
- The arithmetic core carries data only. This block holds each request's ctl field (routing tag) in a FIFO and re-attaches it to the result.
- A credit counter guarantees that every issued operation has a reserved output slot, so results are never dropped when o_res is backpressured.

---
 rtl/tree_res_pipe_adapter_if.sv | 26 ++
 rtl/tree_res_pipe_adapter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/tree_res_pipe_adapter_if.sv
// Single-beat valid/ready stream bundle used by the tree resource-share fabric.
// mod is the byte-count of the last beat; unused on single-beat fixed-width traffic.
interface if_axi_stream #(
  parameter int DAT_BITS = 512,
  parameter int CTL_BITS = 16,
  parameter int MOD_BITS = $clog2(DAT_BITS / 8)
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [MOD_BITS-1:0] mod;
  logic [CTL_BITS-1:0] ctl;

  modport sink (
    input  val, sop, eop, err, dat, mod, ctl,
    output rdy
  );

  modport source (
    output val, sop, eop, err, dat, mod, ctl,
    input  rdy
  );
endinterface

// File: rtl/tree_res_pipe_adapter.sv
// Wraps a fixed-latency, non-stallable core as a stream request/response pair.
// Credits reserve an output slot per issued op, so core results are never dropped.
module tree_res_pipe_adapter #(
  parameter int DAT_BITS = 512,
  parameter int CTL_BITS = 16,
  parameter int LATENCY  = 8,
  parameter int DEPTH    = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  if_axi_stream.sink          i_req,
  if_axi_stream.source        o_res,
  output logic                o_op_val,
  output logic [DAT_BITS-1:0] o_op_dat,
  input  logic                i_op_val,
  input  logic [DAT_BITS-1:0] i_op_dat,
  output logic                o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  if (LATENCY < 1) begin : g_bad_lat
    $error("LATENCY must be at least 1");
  end
  if ((1 << AW) != DEPTH || DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be a power of 2");
  end

  logic [CTL_BITS-1:0] r_ctl_mem  [DEPTH];
  logic [DAT_BITS-1:0] r_dat_mem  [DEPTH];
  logic [CTL_BITS-1:0] r_bctl_mem [DEPTH];

  logic [AW:0]         r_cwr;
  logic [AW:0]         r_crd;
  logic [AW:0]         r_bwr;
  logic [AW:0]         r_brd;
  logic [AW:0]         r_credit;
  logic                r_rdy;
  logic                r_op_val;
  logic [DAT_BITS-1:0] r_op_dat;
  logic                r_res_val;
  logic                r_err;

  logic                w_acc;
  logic                w_res_hs;
  logic                w_ctl_empty;
  logic                w_cap;
  logic                w_spur;
  logic                w_buf_full;
  logic [AW:0]         w_bwr_nxt;
  logic [AW:0]         w_brd_nxt;
  logic [AW:0]         w_credit_nxt;
  logic                w_unused;

  assign w_acc       = i_req.val & r_rdy;
  assign w_res_hs    = r_res_val & o_res.rdy;
  assign w_ctl_empty = (r_cwr == r_crd);
  assign w_cap       = i_op_val & ~w_ctl_empty;
  assign w_spur      = i_op_val & w_ctl_empty;
  assign w_buf_full  = (r_bwr[AW] != r_brd[AW]) &&
                       (r_bwr[AW-1:0] == r_brd[AW-1:0]);
  assign w_bwr_nxt   = w_cap    ? r_bwr + ONE : r_bwr;
  assign w_brd_nxt   = w_res_hs ? r_brd + ONE : r_brd;
  assign w_unused    = ^{i_req.sop, i_req.eop, i_req.err, i_req.mod};

  always_comb begin
    w_credit_nxt = r_credit;
    unique case (1'b1)
      (w_acc & ~w_res_hs): w_credit_nxt = r_credit - ONE;
      (~w_acc & w_res_hs): w_credit_nxt = r_credit + ONE;
      default:             w_credit_nxt = r_credit;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cwr     <= '0;
      r_crd     <= '0;
      r_bwr     <= '0;
      r_brd     <= '0;
      r_credit  <= FULL;
      r_rdy     <= 1'b0;
      r_op_val  <= 1'b0;
      r_op_dat  <= '0;
      r_res_val <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_credit  <= w_credit_nxt;
      r_rdy     <= (w_credit_nxt != '0);
      r_op_val  <= w_acc;
      if (w_acc) begin
        r_op_dat <= i_req.dat;
        r_cwr    <= r_cwr + ONE;
      end
      if (w_cap) begin
        r_crd <= r_crd + ONE;
      end
      r_bwr     <= w_bwr_nxt;
      r_brd     <= w_brd_nxt;
      // Flopped from next pointers: a result captured now is offered next cycle.
      r_res_val <= (w_bwr_nxt != w_brd_nxt);
      if (w_spur) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_acc) begin
      r_ctl_mem[r_cwr[AW-1:0]] <= i_req.ctl;
    end
    if (w_cap) begin
      r_dat_mem[r_bwr[AW-1:0]]  <= i_op_dat;
      r_bctl_mem[r_bwr[AW-1:0]] <= r_ctl_mem[r_crd[AW-1:0]];
    end
  end

  a_no_ovf: assert property (
    @(posedge i_clk) disable iff (!i_rst) !(w_cap && w_buf_full)
  ) else $error("output buffer written while full");

  assign i_req.rdy = r_rdy;
  assign o_op_val  = r_op_val;
  assign o_op_dat  = r_op_dat;
  assign o_err     = r_err;

  assign o_res.val = r_res_val;
  assign o_res.dat = r_dat_mem[r_brd[AW-1:0]];
  assign o_res.ctl = r_bctl_mem[r_brd[AW-1:0]];
  assign o_res.sop = 1'b1;
  assign o_res.eop = 1'b1;
  assign o_res.mod = '0;
  assign o_res.err = 1'b0;

endmodule
